// File: rtl/wb_write_arbiter_pkg.sv
// Shared constants and state encoding for the register-file write-back arbiter.
package wb_arb_pkg;

    localparam int N_REQ      = 8;
    localparam int SEL_W      = 3;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Requester / register-file side bundle of the write-back arbiter.
interface wb_write_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        ack;
    logic [SEL_W-1:0]        mux_sel;
    logic                    rf_we;
    logic [ADDR_W-1:0]       rf_waddr;
    logic                    busy;

    modport master (
        output req, req_addr,
        input  ack, mux_sel, rf_we, rf_waddr, busy
    );

    modport slave (
        input  req, req_addr,
        output ack, mux_sel, rf_we, rf_waddr, busy
    );

endinterface

// File: rtl/wb_write_arbiter_rr_pick8.sv
// Combinational round-robin picker: first set request scanning upward from ptr, wrapping.
module rr_pick8
    import wb_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    // Scan from the farthest offset down so the nearest set bit to ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[ptr + SEL_W'(i)]) begin
                valid = 1'b1;
                idx   = ptr + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Round-robin write-back arbiter driving the 8:1 write-data mux and register-file strobe.
// Optional macro WB_ZERO_GUARD_EN suppresses rf_we for writes to address 0.
module wb_write_arbiter #(
    parameter int N_REQ       = wb_arb_pkg::N_REQ,
    parameter int ADDR_W      = wb_arb_pkg::ADDR_W_DEF,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    wb_write_arbiter_if.slave bus
);

    import wb_arb_pkg::*;

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  hold_cnt, hold_cnt_nxt;
    logic [SEL_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [SEL_W-1:0]  sel_q, sel_nxt;
    logic [ADDR_W-1:0] waddr_q, waddr_nxt;
    logic [N_REQ-1:0]  ack_q, ack_nxt;
    logic              we_q, we_nxt;
    logic              busy_q, busy_nxt;
    logic              pick_valid;
    logic [SEL_W-1:0]  pick_idx;
    logic              zero_block;

    rr_pick8 u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef WB_ZERO_GUARD_EN
    assign zero_block = (waddr_q == '0);
`else
    assign zero_block = 1'b0;
`endif

    // Outputs are computed from the next state so that every port comes straight from a flop.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        rr_ptr_nxt   = rr_ptr;
        sel_nxt      = sel_q;
        waddr_nxt    = waddr_q;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt    = SETUP;
                    sel_nxt      = pick_idx;
                    waddr_nxt    = bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    hold_cnt_nxt = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            SETUP: begin
                if (!bus.req[sel_q]) begin
                    state_nxt = IDLE;
                end else if (hold_cnt == '0) begin
                    state_nxt = WRITE;
                end else begin
                    hold_cnt_nxt = hold_cnt - CNT_W'(1);
                end
            end
            WRITE: begin
                state_nxt  = IDLE;
                rr_ptr_nxt = sel_q + SEL_W'(1);
            end
            default: state_nxt = IDLE;
        endcase

        ack_nxt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ack_nxt[i] = (state_nxt == WRITE) && (sel_q == SEL_W'(i));
        end
        we_nxt   = (state_nxt == WRITE) && !zero_block;
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rr_ptr   <= '0;
            sel_q    <= '0;
            waddr_q  <= '0;
            ack_q    <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
            sel_q    <= sel_nxt;
            waddr_q  <= waddr_nxt;
            ack_q    <= ack_nxt;
            we_q     <= we_nxt;
            busy_q   <= busy_nxt;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.mux_sel  = sel_q;
    assign bus.rf_we    = we_q;
    assign bus.rf_waddr = waddr_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: HOLD_CYCLES=1 and HOLD_CYCLES=3 instances.
module tb_wb_write_arbiter;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    wb_write_arbiter_if #(.ADDR_W(AW)) bus1 ();
    wb_write_arbiter_if #(.ADDR_W(AW)) bus3 ();

    wb_write_arbiter #(.N_REQ(8), .ADDR_W(AW), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));
    wb_write_arbiter #(.N_REQ(8), .ADDR_W(AW), .HOLD_CYCLES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3));

    int errors = 0;
    int checks = 0;
    int ptr1 = 0;
    int ptr3 = 0;

    // Reference: first requester at or after the pointer, wrapping modulo 8.
    function automatic int pick(input logic [7:0] r, input int p);
        for (int o = 0; o < 8; o++) if (r[(p + o) % 8]) return (p + o) % 8;
        return -1;
    endfunction

    function automatic logic exp_we(input logic [AW-1:0] a);
`ifdef WB_ZERO_GUARD_EN
        return (a != '0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [8*AW-1:0] v, input int i);
        return v[i*AW +: AW];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus1.req = '0; bus3.req = '0;
        bus1.req_addr = '0; bus3.req_addr = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ptr1 = 0; ptr3 = 0;
    endtask

    // Waits (bounded) for the next ack pulse; cyc stays 0 on timeout.
    task automatic wait_ack(input int which, output int cyc, output logic [7:0] a,
                            output logic [2:0] sel, output logic we, output logic [AW-1:0] wa);
        cyc = 0; a = '0; sel = '0; we = 1'b0; wa = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            a   = (which == 1) ? bus1.ack : bus3.ack;
            sel = (which == 1) ? bus1.mux_sel : bus3.mux_sel;
            we  = (which == 1) ? bus1.rf_we : bus3.rf_we;
            wa  = (which == 1) ? bus1.rf_waddr : bus3.rf_waddr;
            if (a != '0) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus1.req = 8'hFF; bus3.req = 8'hFF;
        bus1.req_addr = '1; bus3.req_addr = '1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus1.busy, bus1.rf_we, bus1.ack, bus1.mux_sel, bus1.rf_waddr} !== 18'd0) begin
            errors++;
            $display("FAIL reset_h1: got busy=%b we=%b ack=%h sel=%0d wa=%0d want all 0",
                     bus1.busy, bus1.rf_we, bus1.ack, bus1.mux_sel, bus1.rf_waddr);
        end
        checks++;
        if ({bus3.busy, bus3.rf_we, bus3.ack, bus3.mux_sel, bus3.rf_waddr} !== 18'd0) begin
            errors++;
            $display("FAIL reset_h3: got busy=%b we=%b ack=%h sel=%0d wa=%0d want all 0",
                     bus3.busy, bus3.rf_we, bus3.ack, bus3.mux_sel, bus3.rf_waddr);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        bus1.req_addr[2*AW +: AW] = 5'd9;
        bus1.req = 8'h04;
        @(negedge clk);
        checks++;
        if ({bus1.busy, bus1.rf_we, bus1.ack, bus1.mux_sel, bus1.rf_waddr} !== {1'b1, 1'b0, 8'h00, 3'd2, 5'd9}) begin
            errors++;
            $display("FAIL single_setup: got busy=%b we=%b ack=%h sel=%0d wa=%0d want 1 0 00 2 9",
                     bus1.busy, bus1.rf_we, bus1.ack, bus1.mux_sel, bus1.rf_waddr);
        end
        @(negedge clk);
        checks++;
        if ({bus1.busy, bus1.rf_we, bus1.ack, bus1.mux_sel, bus1.rf_waddr} !== {1'b1, exp_we(5'd9), 8'h04, 3'd2, 5'd9}) begin
            errors++;
            $display("FAIL single_write: got busy=%b we=%b ack=%h sel=%0d wa=%0d want 1 1 04 2 9",
                     bus1.busy, bus1.rf_we, bus1.ack, bus1.mux_sel, bus1.rf_waddr);
        end
        bus1.req = 8'h00;
        ptr1 = 3;
        @(negedge clk);
        checks++;
        if ({bus1.busy, bus1.rf_we, bus1.ack, bus1.mux_sel} !== {1'b0, 1'b0, 8'h00, 3'd2}) begin
            errors++;
            $display("FAIL single_idle: got busy=%b we=%b ack=%h sel=%0d want 0 0 00 2",
                     bus1.busy, bus1.rf_we, bus1.ack, bus1.mux_sel);
        end
    endtask

    // All requesters held high: grants must walk 0..7 and wrap to 0.
    task automatic test_wrap();
        logic [8*AW-1:0] av;
        int cyc, g;
        logic [7:0] a; logic [2:0] sel; logic we; logic [AW-1:0] wa;
        do_reset();
        for (int i = 0; i < 8; i++) av[i*AW +: AW] = AW'($urandom_range(1, 31));
        bus1.req_addr = av;
        bus1.req = 8'hFF;
        for (int t = 0; t < 9; t++) begin
            g = pick(8'hFF, ptr1);
            wait_ack(1, cyc, a, sel, we, wa);
            checks++;
            if (a !== 8'(1 << g) || sel !== 3'(t % 8) || wa !== addr_of(av, g) ||
                we !== exp_we(addr_of(av, g)) || cyc != ((t == 0) ? 2 : 3)) begin
                errors++;
                $display("FAIL wrap_%0d: got ack=%h sel=%0d wa=%0d we=%b cyc=%0d want ack=%h sel=%0d wa=%0d cyc=%0d",
                         t, a, sel, wa, we, cyc, 8'(1 << g), t % 8, addr_of(av, g), (t == 0) ? 2 : 3);
            end
            ptr1 = (g + 1) % 8;
        end
        bus1.req = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int cyc, g;
        int exp_seq[5] = '{0, 3, 0, 3, 0};
        logic [7:0] a; logic [2:0] sel; logic we; logic [AW-1:0] wa;
        do_reset();
        bus1.req_addr = {8{5'd7}};
        bus1.req = 8'h01;
        for (int t = 0; t < 5; t++) begin
            g = pick(bus1.req, ptr1);
            wait_ack(1, cyc, a, sel, we, wa);
            checks++;
            if (a !== 8'(1 << exp_seq[t]) || g != exp_seq[t] || sel !== 3'(exp_seq[t])) begin
                errors++;
                $display("FAIL fair_%0d: got ack=%h sel=%0d model=%0d want grant %0d",
                         t, a, sel, g, exp_seq[t]);
            end
            ptr1 = (g + 1) % 8;
            bus1.req = 8'h09;
        end
        bus1.req = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_abort_hold3();
        int cyc, g;
        logic [7:0] a; logic [2:0] sel; logic we; logic [AW-1:0] wa;
        logic seen;
        do_reset();
        bus3.req_addr = 40'({$urandom(), $urandom()});
        bus3.req = 8'h04;
        wait_ack(3, cyc, a, sel, we, wa);
        checks++;
        if (a !== 8'h04 || cyc != 4 || wa !== addr_of(bus3.req_addr, 2) || we !== exp_we(addr_of(bus3.req_addr, 2))) begin
            errors++;
            $display("FAIL hold3_write: got ack=%h cyc=%0d wa=%0d we=%b want ack=04 cyc=4 wa=%0d",
                     a, cyc, wa, we, addr_of(bus3.req_addr, 2));
        end
        bus3.req = 8'h00;
        ptr3 = 3;
        @(negedge clk);
        bus3.req = 8'h20;
        @(negedge clk);
        checks++;
        if (bus3.busy !== 1'b1 || bus3.mux_sel !== 3'd5) begin
            errors++;
            $display("FAIL abort_setup: got busy=%b sel=%0d want 1 5", bus3.busy, bus3.mux_sel);
        end
        @(negedge clk);
        bus3.req = 8'h00;
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            seen = seen | (bus3.ack != 8'h00) | bus3.rf_we;
        end
        checks++;
        if (seen !== 1'b0 || bus3.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_nowrite: got write_seen=%b busy=%b want 0 0", seen, bus3.busy);
        end
        bus3.req = 8'h22;
        g = pick(8'h22, ptr3);
        wait_ack(3, cyc, a, sel, we, wa);
        checks++;
        if (a !== 8'(1 << g) || sel !== 3'(g) || cyc != 4) begin
            errors++;
            $display("FAIL abort_ptr: got ack=%h sel=%0d cyc=%0d want ack=%h sel=%0d cyc=4",
                     a, sel, cyc, 8'(1 << g), g);
        end
        bus3.req = 8'h00;
        ptr3 = (g + 1) % 8;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc, g;
        logic [7:0] a; logic [2:0] sel; logic we; logic [AW-1:0] wa;
        do_reset();
        bus1.req_addr = {8{5'd12}};
        bus1.req = 8'h04;
        wait_ack(1, cyc, a, sel, we, wa);
        bus1.req = 8'h00;
        ptr1 = 3;
        @(negedge clk);
        bus1.req = 8'h10;
        @(negedge clk);
        reset_n = 1'b0;
        bus1.req = 8'h00;
        @(negedge clk);
        checks++;
        if ({bus1.busy, bus1.rf_we, bus1.ack, bus1.mux_sel, bus1.rf_waddr} !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b we=%b ack=%h sel=%0d wa=%0d want all 0",
                     bus1.busy, bus1.rf_we, bus1.ack, bus1.mux_sel, bus1.rf_waddr);
        end
        reset_n = 1'b1;
        ptr1 = 0; ptr3 = 0;
        bus1.req = 8'h09;
        g = pick(8'h09, ptr1);
        wait_ack(1, cyc, a, sel, we, wa);
        checks++;
        if (a !== 8'(1 << g) || cyc != 2) begin
            errors++;
            $display("FAIL reset_ptr: got ack=%h cyc=%0d want ack=%h cyc=2", a, cyc, 8'(1 << g));
        end
        bus1.req = 8'h00;
        ptr1 = (g + 1) % 8;
        @(negedge clk);
    endtask

    task automatic test_zero_addr();
        int cyc;
        logic [7:0] a; logic [2:0] sel; logic we; logic [AW-1:0] wa;
        do_reset();
        bus1.req_addr = {8{5'd3}};
        bus1.req_addr[1*AW +: AW] = '0;
        bus1.req = 8'h02;
        wait_ack(1, cyc, a, sel, we, wa);
        checks++;
        if (a !== 8'h02 || wa !== 5'd0 || we !== exp_we(5'd0) || cyc != 2) begin
            errors++;
            $display("FAIL zero_addr: got ack=%h wa=%0d we=%b cyc=%0d want ack=02 wa=0 we=%b cyc=2",
                     a, wa, we, cyc, exp_we(5'd0));
        end
        bus1.req = 8'h00;
        @(negedge clk);
    endtask

    // Random requests; addresses and other requesters are disturbed after the grant.
    task automatic test_random();
        logic [7:0] r;
        logic [8*AW-1:0] av;
        int g;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            r  = 8'($urandom_range(1, 255));
            av = 40'({$urandom(), $urandom()});
            bus1.req_addr = av;
            bus1.req = r;
            g = pick(r, ptr1);
            @(negedge clk);
            bus1.req_addr = 40'({$urandom(), $urandom()});
            bus1.req = 8'($urandom()) | 8'(1 << g);
            @(negedge clk);
            checks++;
            if (bus1.ack !== 8'(1 << g) || bus1.mux_sel !== 3'(g) || bus1.rf_waddr !== addr_of(av, g) ||
                bus1.rf_we !== exp_we(addr_of(av, g))) begin
                errors++;
                $display("FAIL rand_%0d: got ack=%h sel=%0d wa=%0d we=%b want ack=%h sel=%0d wa=%0d we=%b",
                         it, bus1.ack, bus1.mux_sel, bus1.rf_waddr, bus1.rf_we,
                         8'(1 << g), g, addr_of(av, g), exp_we(addr_of(av, g)));
            end
            bus1.req = 8'h00;
            ptr1 = (g + 1) % 8;
            @(negedge clk);
            checks++;
            if (bus1.busy !== 1'b0 || bus1.ack !== 8'h00 || bus1.rf_we !== 1'b0) begin
                errors++;
                $display("FAIL rand_idle_%0d: got busy=%b ack=%h we=%b want 0 00 0",
                         it, bus1.busy, bus1.ack, bus1.rf_we);
            end
        end
    endtask

    initial begin
        bus1.req = '0; bus3.req = '0;
        bus1.req_addr = '0; bus3.req_addr = '0;
        test_reset();
        test_single();
        test_wrap();
        test_fairness();
        test_abort_hold3();
        test_reset_mid();
        test_zero_addr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
